// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-side boot/fetch stage.
package imem_pkg;

  localparam int unsigned INST_W = 32;

  // addi x0,x0,0
  localparam logic [INST_W-1:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_ERR,
    ST_CKSUM
  } state_e;

endpackage

// File: rtl/imem_ram.sv
// Word-addressed instruction RAM: one synchronous write port, one asynchronous read port.
module imem_ram
  import imem_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH     = 256,
  parameter int unsigned IMEM_ADDR_WIDE = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [IMEM_ADDR_WIDE-1:0] waddr,
  input  logic [INST_W-1:0]         wdata,
  input  logic [IMEM_ADDR_WIDE-1:0] raddr,
  output logic [INST_W-1:0]         rdata
);

  logic [INST_W-1:0] mem [IMEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_boot_fetch.sv
// Boot loader + zero-latency instruction fetch for the single-cycle core.
// Optional trailing checksum beat enabled by defining IMEM_CKSUM_EN.
module imem_boot_fetch
  import imem_pkg::*;
#(
  parameter int unsigned       IMEM_DEPTH     = 256,
  parameter int unsigned       IMEM_ADDR_WIDE = 8,
  parameter logic [INST_W-1:0] NOP_INST       = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [INST_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [31:0]       pc,
  output logic [INST_W-1:0] inst,
  output logic              core_nrst,
  output logic              load_done,
  output logic              load_err,
  output logic              fetch_fault
);

  localparam int unsigned AW = IMEM_ADDR_WIDE;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]     load_count_q, load_count_d;
  logic            load_done_q, load_done_d;
  logic            core_nrst_q, core_nrst_d;
  logic            load_err_q, load_err_d;
  logic            fetch_fault_q, fetch_fault_d;
`ifdef IMEM_CKSUM_EN
  logic [INST_W-1:0] sum_q, sum_d;
`endif

  logic              beat;
  logic              we;
  logic [AW-1:0]     idx;
  logic              pc_bad;
  logic              running;
  logic [INST_W-1:0] rdata;

  imem_ram #(
    .IMEM_DEPTH    (IMEM_DEPTH),
    .IMEM_ADDR_WIDE(IMEM_ADDR_WIDE)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q),
    .wdata(ld_data),
    .raddr(idx),
    .rdata(rdata)
  );

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    load_count_d  = load_count_q;
    fetch_fault_d = fetch_fault_q;
    we            = 1'b0;
`ifdef IMEM_CKSUM_EN
    sum_d         = sum_q;
`endif

    // Gated by rst so no beat is reported accepted while the block is being cleared.
    ld_ready = !rst && (state_q == ST_LOAD || state_q == ST_CKSUM);
    beat     = ld_valid && ld_ready;

    case (state_q)
      ST_LOAD: begin
        if (beat) begin
          we           = 1'b1;
          wr_ptr_d     = wr_ptr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
`ifdef IMEM_CKSUM_EN
          sum_d        = sum_q + ld_data;
          if (ld_last) state_d = ST_CKSUM;
`else
          if (ld_last) state_d = ST_RUN;
`endif
          else if (wr_ptr_q == AW'(IMEM_DEPTH - 1)) state_d = ST_ERR;
        end
      end
`ifdef IMEM_CKSUM_EN
      ST_CKSUM: begin
        if (beat) state_d = (ld_data == sum_q) ? ST_RUN : ST_ERR;
      end
`endif
      default: ;
    endcase

    idx     = pc[AW+1:2];
    running = (state_q == ST_RUN);
    pc_bad  = (pc[1:0] != 2'b00) || (pc[31:AW+2] != '0);

    inst = NOP_INST;
    if (running && !pc_bad && ({1'b0, idx} < load_count_q)) inst = rdata;
    if (running && pc_bad) fetch_fault_d = 1'b1;

    load_done_d = (state_d == ST_RUN);
    core_nrst_d = (state_d == ST_RUN);
    load_err_d  = (state_d == ST_ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      wr_ptr_q      <= '0;
      load_count_q  <= '0;
      load_done_q   <= 1'b0;
      core_nrst_q   <= 1'b0;
      load_err_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
`ifdef IMEM_CKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      load_count_q  <= load_count_d;
      load_done_q   <= load_done_d;
      core_nrst_q   <= core_nrst_d;
      load_err_q    <= load_err_d;
      fetch_fault_q <= fetch_fault_d;
`ifdef IMEM_CKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign load_done   = load_done_q;
  assign core_nrst   = core_nrst_q;
  assign load_err    = load_err_q;
  assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_imem_boot_fetch.sv
// Self-checking bench for imem_boot_fetch (default and IMEM_CKSUM_EN builds).
module tb_imem_boot_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst, ld_valid, ld_ready, ld_last;
  logic [31:0] ld_data, pc, inst;
  logic        core_nrst, load_done, load_err, fetch_fault;

  logic        s_rst, s_ld_valid, s_ld_ready, s_ld_last;
  logic [31:0] s_ld_data, s_pc, s_inst;
  logic        s_core_nrst, s_load_done, s_load_err, s_fetch_fault;

  int checks = 0;
  int errors = 0;

  // behavioural model: loaded image and run/fault status
  logic [31:0] mwords[$];
  bit          mrun;
  bit          mfault;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
  } fvec_t;
  fvec_t tbl[9];

  imem_boot_fetch u_dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .pc(pc), .inst(inst),
    .core_nrst(core_nrst), .load_done(load_done), .load_err(load_err),
    .fetch_fault(fetch_fault)
  );

  imem_boot_fetch #(.IMEM_DEPTH(4), .IMEM_ADDR_WIDE(2)) u_small (
    .clk(clk), .rst(s_rst), .ld_valid(s_ld_valid), .ld_ready(s_ld_ready),
    .ld_data(s_ld_data), .ld_last(s_ld_last), .pc(s_pc), .inst(s_inst),
    .core_nrst(s_core_nrst), .load_done(s_load_done), .load_err(s_load_err),
    .fetch_fault(s_fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b0; ld_last = 1'b0; pc = 32'h0;
    #1 chk("rst_ld_ready", {31'b0, ld_ready}, 0);
    @(negedge clk);
    chk("rst_ld_ready2", {31'b0, ld_ready}, 0);
    chk("rst_core_nrst", {31'b0, core_nrst}, 0);
    chk("rst_load_done", {31'b0, load_done}, 0);
    chk("rst_load_err", {31'b0, load_err}, 0);
    chk("rst_fetch_fault", {31'b0, fetch_fault}, 0);
    chk("rst_inst", inst, NOP);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ld_ready", {31'b0, ld_ready}, 1);
    mwords.delete(); mrun = 0; mfault = 0;
  endtask

  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input logic [31:0] d, input bit last, input bit expect_run);
    int n = 0;
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    #1;
    while (!ld_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (!ld_ready) begin
      chk("beat_timeout", {31'b0, ld_ready}, 1);
      ld_valid = 1'b0;
      return;
    end
    if (expect_run) chk("nrst_before_run", {31'b0, core_nrst}, 0);
    @(negedge clk);
    ld_valid = 1'b0; ld_last = 1'b0;
    if (expect_run) begin
      chk("nrst_after_run", {31'b0, core_nrst}, 1);
      chk("load_done_run", {31'b0, load_done}, 1);
      chk("ld_ready_run", {31'b0, ld_ready}, 0);
    end
  endtask

  task automatic load_program(input logic [31:0] w[$], input bit gaps);
    logic [31:0] sum = 32'h0;
    for (int i = 0; i < w.size(); i++) begin
      bit last = (i == w.size() - 1);
`ifdef IMEM_CKSUM_EN
      send_beat(w[i], last, 1'b0);
`else
      send_beat(w[i], last, last);
`endif
      sum += w[i];
      if (gaps && !last) @(negedge clk);
    end
`ifdef IMEM_CKSUM_EN
    send_beat(sum, 1'b0, 1'b1);
`endif
    mwords = w; mrun = 1; mfault = 0;
  endtask

  task automatic fetch_chk(input logic [31:0] p, input string name);
    logic [31:0] exp = NOP;
    bit bad = (p[1:0] != 2'b00) || (p >= 32'h400);
    pc = p;
    if (mrun && !bad && (p / 4) < mwords.size()) exp = mwords[p / 4];
    #1 chk(name, inst, exp);
    if (mrun && bad) mfault = 1;
    @(negedge clk);
    chk({name, "_fault"}, {31'b0, fetch_fault}, {31'b0, mfault});
  endtask

  initial begin
    logic [31:0] w[$];
    logic [31:0] p;
    int n;

    rst = 1'b1; ld_valid = 0; ld_data = 0; ld_last = 0; pc = 0;
    s_rst = 1'b1; s_ld_valid = 0; s_ld_data = 0; s_ld_last = 0; s_pc = 0;

    tbl[0] = '{32'h0000_0000, 32'h0030_0093, 1'b0};
    tbl[1] = '{32'h0000_0004, 32'hFFF0_8093, 1'b0};
    tbl[2] = '{32'h0000_0008, 32'h0010_80B3, 1'b0};
    tbl[3] = '{32'h0000_000C, NOP,           1'b0};
    tbl[4] = '{32'h0000_03FC, NOP,           1'b0};
    tbl[5] = '{32'h0000_0002, NOP,           1'b1};
    tbl[6] = '{32'h0000_0000, 32'h0030_0093, 1'b1};
    tbl[7] = '{32'h0000_0400, NOP,           1'b1};
    tbl[8] = '{32'h8000_0000, NOP,           1'b1};

    // basic load + table-driven fetches
    do_reset();
    pc = 32'h2;
    @(negedge clk);
    chk("load_no_fault", {31'b0, fetch_fault}, 0);
    chk("load_inst_nop", inst, NOP);
    load_program('{32'h0030_0093, 32'hFFF0_8093, 32'h0010_80B3}, 1'b0);
    for (int i = 0; i < 9; i++) begin
      pc = tbl[i].pc;
      #1 chk($sformatf("tbl%0d_inst", i), inst, tbl[i].inst);
      @(negedge clk);
      chk($sformatf("tbl%0d_fault", i), {31'b0, fetch_fault}, {31'b0, tbl[i].fault});
    end
    ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
    repeat (3) @(negedge clk);
    ld_valid = 1'b0;
    chk("fault_sticky", {31'b0, fetch_fault}, 1);
    chk("run_ignores_ld", {31'b0, ld_ready}, 0);
    mfault = 1;
    fetch_chk(32'h4, "run_after_noise");

    // gaps between beats: valid 1,0,1,0,1
    do_reset();
    load_program('{32'h1111_0001, 32'h2222_0002, 32'h3333_0003}, 1'b1);
    for (int i = 0; i < 4; i++) fetch_chk(32'(i * 4), $sformatf("gap_pc%0d", i));

    // reset mid-load, then fresh one-word load
    do_reset();
    send_beat(32'hAAAA_0000, 1'b0, 1'b0);
    send_beat(32'hBBBB_0001, 1'b0, 1'b0);
    ld_valid = 1'b1; ld_data = 32'hCCCC_0002; rst = 1'b1;
    #1 chk("midrst_ld_ready", {31'b0, ld_ready}, 0);
    @(negedge clk);
    chk("midrst_ld_ready2", {31'b0, ld_ready}, 0);
    chk("midrst_nrst", {31'b0, core_nrst}, 0);
    rst = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    mwords.delete(); mrun = 0; mfault = 0;
    load_program('{32'h0000_0ABC}, 1'b0);
    fetch_chk(32'h0, "midrst_pc0");
    fetch_chk(32'h4, "midrst_pc4_stale");

    // full image
    do_reset();
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back(32'h5A00_0000 + 32'(i));
    load_program(w, 1'b0);
    fetch_chk(32'h3FC, "full_last");
    fetch_chk(32'h200, "full_mid");
    fetch_chk(32'h400, "full_oor");

    // randomized loads and fetches against the model
    for (int r = 0; r < 6; r++) begin
      do_reset();
      n = $urandom_range(1, 24);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      load_program(w, bit'($urandom_range(0, 1)));
      for (int k = 0; k < 40; k++) begin
        case ($urandom_range(0, 9))
          0:       p = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
          1:       p = $urandom | 32'h400;
          default: p = 32'($urandom_range(0, n + 3)) << 2;
        endcase
        ld_valid = 1'($urandom_range(0, 1)); ld_data = $urandom; ld_last = 1'($urandom_range(0, 1));
        fetch_chk(p, $sformatf("rnd%0d_%0d", r, k));
      end
      ld_valid = 1'b0; ld_last = 1'b0;
    end

`ifdef IMEM_CKSUM_EN
    do_reset();
    send_beat(32'd1, 1'b0, 1'b0);
    send_beat(32'd2, 1'b0, 1'b0);
    send_beat(32'd3, 1'b1, 1'b0);
    chk("ck_wait_nrst", {31'b0, core_nrst}, 0);
    chk("ck_wait_ready", {31'b0, ld_ready}, 1);
    send_beat(32'd6, 1'b1, 1'b1);
    mwords = '{32'd1, 32'd2, 32'd3}; mrun = 1;
    fetch_chk(32'h8, "ck_good_pc8");
    do_reset();
    send_beat(32'd1, 1'b0, 1'b0);
    send_beat(32'd2, 1'b0, 1'b0);
    send_beat(32'd3, 1'b1, 1'b0);
    send_beat(32'd7, 1'b0, 1'b0);
    chk("ck_bad_err", {31'b0, load_err}, 1);
    chk("ck_bad_nrst", {31'b0, core_nrst}, 0);
    chk("ck_bad_ready", {31'b0, ld_ready}, 0);
    fetch_chk(32'h0, "ck_bad_inst");
`endif

    // overflow on the 4-word instance
    @(negedge clk);
    s_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_ld_valid = 1'b1; s_ld_data = 32'h100 + 32'(i); s_ld_last = 1'b0;
      #1 chk($sformatf("ovf_ready%0d", i), {31'b0, s_ld_ready}, 1);
      @(negedge clk);
    end
    s_ld_valid = 1'b0;
    chk("ovf_err", {31'b0, s_load_err}, 1);
    chk("ovf_ready", {31'b0, s_ld_ready}, 0);
    chk("ovf_nrst", {31'b0, s_core_nrst}, 0);
    chk("ovf_done", {31'b0, s_load_done}, 0);
    for (int i = 0; i < 4; i++) begin
      s_pc = 32'(i * 4);
      #1 chk($sformatf("ovf_inst%0d", i), s_inst, NOP);
      @(negedge clk);
    end
    chk("ovf_no_fault", {31'b0, s_fetch_fault}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
